pipe_skid_reg: RTL

- Parametrised successor to the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control field and a data field between two CPU stages through a valid/ready elastic handshake with a 2-entry skid buffer, so both in_ready and all outputs are driven from flops.
- Adds what the fixed registers lack: stall back-pressure, flush that inserts a NOP bubble, a configurable data-clear mode, and saturating stall/bubble performance counters.

---
 rtl/pipe_skid_reg.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pipe_skid_reg.sv
// Elastic inter-stage pipeline register: a main entry plus a one-deep skid entry,
// with flush-to-bubble and saturating stall/bubble counters. All outputs come from flops.
module pipe_skid_reg #(
    parameter int CTRL_W             = 16,
    parameter int DATA_W             = 96,
    parameter int ZERO_DATA_ON_FLUSH = 0,
    parameter int CNT_W              = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              clear_counts,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  bubble_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e            state_q,      state_d;
    logic              in_ready_q,   in_ready_d;
    logic              out_valid_q,  out_valid_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    logic accept;
    logic emit;

    assign accept = in_valid & in_ready_q;
    assign emit   = out_valid_q & out_ready;

    // Main ctrl is cleared whenever the stage empties, so out_ctrl can be the
    // flop itself and still read as NOP on every bubble.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            if (ZERO_DATA_ON_FLUSH != 0) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                        state_d     = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (emit && accept) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (emit) begin
                        main_ctrl_d = '0;
                        state_d     = ST_EMPTY;
                    end else if (accept) begin
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                        state_d     = ST_SKID;
                    end
                end
                ST_SKID: begin
                    if (emit) begin
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        state_d     = ST_FULL;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_ctrl_d = '0;
                end
            endcase
        end

        in_ready_d  = (state_d != ST_SKID);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // Counters look at the pre-edge handshake state and ignore flush.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (clear_counts) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
        end else begin
            if (out_valid_q && !out_ready && (stall_cnt_q != CNT_MAX))
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            if (!out_valid_q && (bubble_cnt_q != CNT_MAX))
                bubble_cnt_d = bubble_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the payload entries are reset too; they are plain flops, and out_data must read zero out of reset.
            state_q      <= ST_EMPTY;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            main_ctrl_q  <= '0;
            main_data_q  <= '0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge values, whatever the statement order.
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_ctrl     = main_ctrl_q;
    assign out_data     = main_data_q;
    assign stall_count  = stall_cnt_q;
    assign bubble_count = bubble_cnt_q;

`ifndef SYNTHESIS
    a_bubble_is_nop : assert property (@(posedge clock) disable iff (!reset)
        !out_valid_q |-> (main_ctrl_q == '0));
    a_ready_tracks_state : assert property (@(posedge clock) disable iff (!reset)
        in_ready_q == (state_q != ST_SKID));
    a_valid_tracks_state : assert property (@(posedge clock) disable iff (!reset)
        out_valid_q == (state_q != ST_EMPTY));
`endif

endmodule
